// File: rtl/grid_renderer.sv
// N x N board pixel renderer: divider-free cell tracking, frame snapshots,
// selection cursor and blinking win highlight, two-tick pipeline to the pins.
module grid_renderer #(
  parameter int          GRID_N       = 3,
  parameter int          CELL         = 144,
  parameter int          LINE_W       = 3,
  parameter int          ORIGIN_X     = 100,
  parameter int          ORIGIN_Y     = 20,
  parameter int          MARK_INSET   = 30,
  parameter int          BAR_HALF     = 8,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] COLOR_BG     = 12'h000,
  parameter logic [11:0] COLOR_LINE   = 12'hFFF,
  parameter logic [11:0] COLOR_P1     = 12'hF00,
  parameter logic [11:0] COLOR_P2     = 12'hFFF,
  parameter logic [11:0] COLOR_CURSOR = 12'h0F0,
  parameter logic [11:0] COLOR_WIN    = 12'hFF0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [9:0]                   x,
  input  logic [9:0]                   y,
  input  logic                         video_on,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic [2*GRID_N*GRID_N-1:0]   tiles,
  input  logic [5:0]                   cursor,
  input  logic                         cursor_en,
  input  logic [GRID_N*GRID_N-1:0]     win_mask,
  output logic                         hsync,
  output logic                         vsync,
  output logic [11:0]                  rgb
);

  localparam int NC = GRID_N * GRID_N;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FM1 = FW'(BLINK_FRAMES - 1);
  localparam logic [2:0] NM1 = 3'(GRID_N - 1);
  localparam logic [9:0] OX  = 10'(ORIGIN_X);
  localparam logic [9:0] OY  = 10'(ORIGIN_Y);
  localparam logic [9:0] PM1 = 10'(CELL + LINE_W - 1);
  localparam logic [9:0] CM1 = 10'(CELL - 1);
  localparam logic [9:0] CE  = 10'(CELL);
  localparam logic [9:0] LW  = 10'(LINE_W);
  localparam logic [9:0] CEL = 10'(CELL - LINE_W);
  localparam logic [9:0] MI  = 10'(MARK_INSET);
  localparam logic [9:0] MO  = 10'(CELL - MARK_INSET);
  localparam logic [9:0] BL  = 10'(CELL / 2 - BAR_HALF);
  localparam logic [9:0] BH  = 10'(CELL / 2 + BAR_HALF);

  logic [2:0]      r_col, r_row, w_col, w_row;
  logic [9:0]      r_offx, r_offy, w_offx, w_offy;
  logic            r_inx, r_iny, w_inx, w_iny;
  logic [2*NC-1:0] r_tiles, w_tiles;
  logic [NC-1:0]   r_win, w_win;
  logic [5:0]      r_cursor, w_cursor;
  logic            r_cen, w_cen;
  logic [FW-1:0]   r_cnt, w_cnt;
  logic            r_ph, w_ph;
  logic            w_fs;

  logic r_s1_vo, r_s1_hs, r_s1_vs;
  logic r_s1_line, r_s1_cur, r_s1_mark, r_s1_p2, r_s1_hl;
  logic w_in, w_line, w_edge, w_cur, w_mark;
  logic w_sqx, w_sqy, w_bx, w_by, w_sq, w_plus;
  logic [5:0]  w_cell;
  logic [1:0]  w_code;
  logic        w_wbit;
  logic [11:0] w_rgb;

  assign w_fs = tick & (x == '0) & (y == '0);

  // Snapshot takes effect on the frame-start pixel itself.
  assign w_tiles  = w_fs ? tiles     : r_tiles;
  assign w_win    = w_fs ? win_mask  : r_win;
  assign w_cursor = w_fs ? cursor    : r_cursor;
  assign w_cen    = w_fs ? cursor_en : r_cen;

  always_comb begin
    w_col  = r_col;
    w_offx = r_offx;
    w_inx  = r_inx;
    if (x == OX) begin
      w_col  = '0;
      w_offx = '0;
      w_inx  = 1'b1;
    end else if (r_inx) begin
      if (r_col == NM1 && r_offx == CM1) begin
        w_inx = 1'b0;
      end else if (r_offx == PM1) begin
        w_offx = '0;
        w_col  = r_col + 3'd1;
      end else begin
        w_offx = r_offx + 10'd1;
      end
    end
  end

  always_comb begin
    w_row  = r_row;
    w_offy = r_offy;
    w_iny  = r_iny;
    if (x == '0) begin
      if (y == OY) begin
        w_row  = '0;
        w_offy = '0;
        w_iny  = 1'b1;
      end else if (r_iny) begin
        if (r_row == NM1 && r_offy == CM1) begin
          w_iny = 1'b0;
        end else if (r_offy == PM1) begin
          w_offy = '0;
          w_row  = r_row + 3'd1;
        end else begin
          w_offy = r_offy + 10'd1;
        end
      end
    end
  end

  // Blink only advances across frames whose old and new masks are both set.
  always_comb begin
    w_cnt = r_cnt;
    w_ph  = r_ph;
    if (w_fs) begin
      if (win_mask == '0) begin
        w_cnt = '0;
        w_ph  = 1'b0;
      end else if (r_win != '0) begin
        if (r_cnt == FM1) begin
          w_cnt = '0;
          w_ph  = ~r_ph;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
    end
  end

  assign w_in   = w_inx & w_iny;
  assign w_cell = {3'b0, w_row} * 6'(GRID_N) + {3'b0, w_col};
  assign w_line = w_in & ((w_offx >= CE) | (w_offy >= CE));
  assign w_edge = (w_offx < LW) | (w_offx >= CEL) |
                  (w_offy < LW) | (w_offy >= CEL);
  assign w_cur  = w_in & w_cen & w_edge & (w_cursor == w_cell) &
                  ({1'b0, w_cursor} < 7'(NC));
  assign w_sqx  = (w_offx >= MI) & (w_offx < MO);
  assign w_sqy  = (w_offy >= MI) & (w_offy < MO);
  assign w_bx   = (w_offx >= BL) & (w_offx < BH);
  assign w_by   = (w_offy >= BL) & (w_offy < BH);
  assign w_sq   = w_sqx & w_sqy;
  assign w_plus = (w_bx & w_sqy) | (w_by & w_sqx);

  always_comb begin
    w_code = '0;
    w_wbit = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (w_cell == 6'(i)) begin
        w_code = w_tiles[2*i +: 2];
        w_wbit = w_win[i];
      end
    end
  end

  assign w_mark = w_in & (((w_code == 2'b01) & w_sq) |
                          ((w_code == 2'b10) & w_plus));

  always_comb begin
    w_rgb = COLOR_BG;
    if (!r_s1_vo)       w_rgb = '0;
    else if (r_s1_line) w_rgb = COLOR_LINE;
    else if (r_s1_cur)  w_rgb = COLOR_CURSOR;
    else if (r_s1_mark) w_rgb = r_s1_hl ? COLOR_WIN :
                                (r_s1_p2 ? COLOR_P2 : COLOR_P1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col     <= '0;
      r_row     <= '0;
      r_offx    <= '0;
      r_offy    <= '0;
      r_inx     <= 1'b0;
      r_iny     <= 1'b0;
      r_tiles   <= '0;
      r_win     <= '0;
      r_cursor  <= '0;
      r_cen     <= 1'b0;
      r_cnt     <= '0;
      r_ph      <= 1'b0;
      r_s1_vo   <= 1'b0;
      r_s1_hs   <= 1'b0;
      r_s1_vs   <= 1'b0;
      r_s1_line <= 1'b0;
      r_s1_cur  <= 1'b0;
      r_s1_mark <= 1'b0;
      r_s1_p2   <= 1'b0;
      r_s1_hl   <= 1'b0;
      rgb       <= '0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
    end else if (tick) begin
      r_col     <= w_col;
      r_row     <= w_row;
      r_offx    <= w_offx;
      r_offy    <= w_offy;
      r_inx     <= w_inx;
      r_iny     <= w_iny;
      r_tiles   <= w_tiles;
      r_win     <= w_win;
      r_cursor  <= w_cursor;
      r_cen     <= w_cen;
      r_cnt     <= w_cnt;
      r_ph      <= w_ph;
      r_s1_vo   <= video_on;
      r_s1_hs   <= hsync_in;
      r_s1_vs   <= vsync_in;
      r_s1_line <= w_line;
      r_s1_cur  <= w_cur;
      r_s1_mark <= w_mark;
      r_s1_p2   <= (w_code == 2'b10);
      r_s1_hl   <= w_wbit & w_ph;
      rgb       <= w_rgb;
      hsync     <= r_s1_hs;
      vsync     <= r_s1_vs;
    end
  end

endmodule
